ahb_sram_slave: RTL and testbench

//  AHB-Lite responder paired with AHB_Master: word-organised SRAM slave with programmable wait states and ERROR responses.

---
 rtl/ahb_pkg.sv | 54 +++++
 rtl/ahb_slave_mem.sv | 31 +++
 rtl/ahb_sram_slave.sv | 130 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings (HTRANS, HSIZE, HRESP, HBURST), the SRAM
// slave FSM state type and the byte-lane helper used by the slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } slave_state_e;

    // Little-endian byte enables for a legal, aligned transfer.
    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        if (size == HSIZE_BYTE) begin
            be = 4'b0001 << lane;
        end else if (size == HSIZE_HALF) begin
            be = lane[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: MEM_DEPTH x 32-bit storage, byte-enable synchronous write,
// asynchronous read. Contents are never reset.
//  clk    in   clock
//  addr   in   word index (shared by read and write)
//  be     in   per-byte write enables, bit n writes wdata[8n+7:8n]
//  wdata  in   write data
//  rdata  out  word at addr (combinational)
module ahb_slave_mem #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned IDX_W     = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-organised SRAM responder with programmable
// wait states and two-cycle ERROR responses for out-of-range, illegal-size or
// misaligned transfers.
//  HCLK/HRESETn          clock, synchronous active-low reset
//  HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST  address phase (HBURST unused)
//  HWDATA                write data, sampled in the data cycle only
//  HREADY                bus-level ready from the HREADY mux
//  HREADYOUT/HRESP/HRDATA  this slave's response
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    import ahb_pkg::*;

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    slave_state_e     state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [2:0]       size_q;
    logic             write_q;

    logic [31:0] offset;
    logic        accept, addr_err, take;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        unused_hburst;

    assign unused_hburst = ^HBURST;

    // Below-base addresses wrap to a huge offset and fall into the range error.
    assign offset   = HADDR - BASE_ADDR;
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign addr_err = (offset >= 32'(4 * MEM_DEPTH))
                    | (HSIZE > HSIZE_WORD)
                    | ((HSIZE == HSIZE_HALF) & HADDR[0])
                    | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));
    assign take     = accept & ((state_q == StIdle) | (state_q == StData) | (state_q == StErr2));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        unique case (state_q)
            StWait: begin
                HREADYOUT = 1'b0;
                if (wait_cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = StErr2;
            end
            default: begin
                // StIdle, StData and StErr2 share the acceptance rule.
                if (state_q == StErr2) begin
                    HRESP = HRESP_ERROR;
                end
                if (!accept) begin
                    state_d = StIdle;
                end else if (addr_err) begin
                    state_d = StErr1;
                end else if (WAIT_STATES > 0) begin
                    state_d    = StWait;
                    wait_cnt_d = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = StData;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 3'b000;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (take) begin
                idx_q   <= offset[IDX_W+1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    // Reset on the closing edge of a data cycle must not commit the write.
    assign mem_be = (state_q == StData && write_q && HRESETn) ? lane_enable(size_q, lane_q)
                                                               : 4'b0000;
    assign HRDATA = (state_q == StData && !write_q) ? mem_rdata : 32'h0;

    ahb_slave_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .IDX_W    (IDX_W)
    ) u_mem (
        .clk  (HCLK),
        .addr (idx_q),
        .be   (mem_be),
        .wdata(HWDATA),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct packed {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    // One expected response cycle.
    typedef struct {
        bit         ready;
        bit         resp;
        bit         rd;
        bit         wr;
        int         idx;
        logic [3:0] be;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        stall     [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int checks = 0;
    int errors = 0;

    op_t         ops      [$];
    logic [31:0] rd_data  [$];
    logic        rd_resp  [$];
    int          rd_stall [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit ready, input bit resp, input bit rd, input bit wr,
                                input int idx, input logic [3:0] be);
        exp_t e;
        e.ready = ready; e.resp = resp; e.rd = rd; e.wr = wr; e.idx = idx; e.be = be;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : 2;

        assign hready[g] = hreadyout[g] & ~stall[g];

        ahb_sram_slave #(
            .BASE_ADDR  (BASE),
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES(WS)
        ) u_dut (
            .HCLK     (clk),
            .HRESETn  (rst_n),
            .HSEL     (hsel[g]),
            .HADDR    (haddr[g]),
            .HTRANS   (htrans[g]),
            .HWRITE   (hwrite[g]),
            .HSIZE    (hsize[g]),
            .HBURST   (hburst[g]),
            .HWDATA   (hwdata[g]),
            .HREADY   (hready[g]),
            .HREADYOUT(hreadyout[g]),
            .HRESP    (hresp[g]),
            .HRDATA   (hrdata[g])
        );

        // Transaction-level model: each accepted transfer expands into its
        // response cycles; memory is a plain array with per-byte known flags.
        exp_t        q     [$];
        logic [31:0] mm    [DEPTH];
        logic [3:0]  known [DEPTH];
        bit          rst_seen = 1'b0;

        initial begin : model
            exp_t        cur;
            logic [31:0] off, mask;
            logic [3:0]  be;
            int          nb;
            bit          err;
            for (int i = 0; i < int'(DEPTH); i++) known[i] = 4'h0;
            forever begin
                @(negedge clk);
                cur = (q.size() != 0) ? q.pop_front() : mk(1, 0, 0, 0, 0, 4'h0);
                if (rst_seen) begin
                    chk($sformatf("hreadyout[%0d]", g), 32'(hreadyout[g]), 32'(cur.ready));
                    chk($sformatf("hresp[%0d]", g), 32'(hresp[g]), 32'(cur.resp));
                    if (cur.rd) begin
                        mask = {{8{known[cur.idx][3]}}, {8{known[cur.idx][2]}},
                                {8{known[cur.idx][1]}}, {8{known[cur.idx][0]}}};
                        chk($sformatf("hrdata[%0d]", g), hrdata[g] & mask, mm[cur.idx] & mask);
                    end else if (!cur.wr) begin
                        chk($sformatf("hrdata_idle[%0d]", g), hrdata[g], 32'h0);
                    end
                end
                if (!rst_n) begin
                    q.delete();
                    rst_seen = 1'b1;
                end else begin
                    if (cur.wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cur.be[b]) begin
                                mm[cur.idx][8*b +: 8] = hwdata[g][8*b +: 8];
                                known[cur.idx][b] = 1'b1;
                            end
                        end
                    end
                    if (hsel[g] && cur.ready && !stall[g] && htrans[g][1]) begin
                        off = haddr[g] - BASE;
                        nb  = 1;
                        if (hsize[g] > 3'd2) begin
                            err = 1'b1;
                        end else begin
                            nb  = 1 << hsize[g];
                            err = (off >= 4 * DEPTH) || ((int'(haddr[g][1:0]) % nb) != 0);
                        end
                        if (err) begin
                            q.push_back(mk(0, 1, 0, 0, 0, 4'h0));
                            q.push_back(mk(1, 1, 0, 0, 0, 4'h0));
                        end else begin
                            be = 4'(((1 << nb) - 1) << haddr[g][1:0]);
                            for (int i = 0; i < int'(WS); i++) q.push_back(mk(0, 0, 0, 0, 0, 4'h0));
                            q.push_back(mk(1, 0, !hwrite[g], hwrite[g], int'(off >> 2), be));
                        end
                    end
                end
            end
        end
    end

    task automatic add(input logic [1:0] t, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.trans = t; o.write = w; o.size = s; o.addr = a; o.wdata = d;
        ops.push_back(o);
    endtask

    // Pipelined master: runs ops on DUT d, recording per data phase the
    // final-cycle HRDATA/HRESP and the number of stalled cycles.
    task automatic run_ops(input int d, input bit rnd_stall);
        int  ai  = 0;
        int  st  = 0;
        int  cyc = 0;
        bit  dv  = 1'b0;
        bit  rdy;
        op_t dop;
        rd_data.delete(); rd_resp.delete(); rd_stall.delete();
        dop = '0;
        while (ai < ops.size() || dv) begin
            if (ai < ops.size()) begin
                hsel[d] = 1'b1; htrans[d] = ops[ai].trans; hwrite[d] = ops[ai].write;
                hsize[d] = ops[ai].size; haddr[d] = ops[ai].addr;
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hburst[d] = 3'($urandom_range(0, 7));
            hwdata[d] = dv ? dop.wdata : $urandom();
            stall[d]  = rnd_stall && !dv && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            rdy = hready[d];
            if (dv) begin
                if (!rdy) begin
                    st++;
                end else begin
                    rd_data.push_back(hrdata[d]); rd_resp.push_back(hresp[d]);
                    rd_stall.push_back(st); st = 0;
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                dv = (ai < ops.size()) && ops[ai].trans[1];
                if (dv) dop = ops[ai];
                if (ai < ops.size()) ai++;
            end
            cyc++;
            if (cyc > 4000) begin
                checks++; errors++;
                $display("FAIL timeout on dut %0d: got %0d cycles required < 4000", d, cyc);
                break;
            end
        end
        hsel[d] = 1'b0; htrans[d] = 2'b00; stall[d] = 1'b0;
        ops.delete();
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            hsize[d] = 3'b010; hburst[d] = 3'b000; hwdata[d] = '0; stall[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_hreadyout", 32'(hreadyout[d]), 32'h1);
            chk("reset_hresp", 32'(hresp[d]), 32'h0);
            chk("reset_hrdata", hrdata[d], 32'h0);
        end
        rst_n = 1'b1;

        // Zero wait states: back-to-back write then read.
        add(2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        add(2'b10, 0, 3'd2, 32'h10, 32'h0);
        run_ops(0, 0);
        chk("ws0_read", rd_data[1], 32'hDEADBEEF);
        chk("ws0_stall_wr", 32'(rd_stall[0]), 32'd0);
        chk("ws0_stall_rd", 32'(rd_stall[1]), 32'd0);
        chk("ws0_resp", 32'(rd_resp[1]), 32'h0);

        // Byte and halfword lanes.
        add(2'b10, 1, 3'd2, 32'h30, 32'h11223344);
        add(2'b10, 1, 3'd0, 32'h33, 32'hAA000000);
        add(2'b10, 0, 3'd2, 32'h30, 32'h0);
        add(2'b10, 1, 3'd1, 32'h32, 32'hBEEF0000);
        add(2'b10, 0, 3'd2, 32'h30, 32'h0);
        run_ops(0, 0);
        chk("byte_lane", rd_data[2], 32'hAA223344);
        chk("half_lane", rd_data[4], 32'hBEEF3344);

        // ERROR responses leave memory untouched.
        add(2'b10, 1, 3'd2, 32'h00, 32'h55555555);
        add(2'b10, 1, 3'd2, 32'h02, 32'h00000000);
        add(2'b10, 0, 3'd2, 32'h400, 32'h0);
        add(2'b10, 0, 3'd2, 32'h00, 32'h0);
        run_ops(0, 0);
        chk("err_misalign_resp", 32'(rd_resp[1]), 32'h1);
        chk("err_misalign_stall", 32'(rd_stall[1]), 32'd1);
        chk("err_range_resp", 32'(rd_resp[2]), 32'h1);
        chk("err_range_stall", 32'(rd_stall[2]), 32'd1);
        chk("err_mem_unchanged", rd_data[3], 32'h55555555);

        // INCR4 burst with one BUSY beat.
        add(2'b10, 1, 3'd2, 32'h40, 32'd1);
        add(2'b11, 1, 3'd2, 32'h44, 32'd2);
        add(2'b01, 1, 3'd2, 32'h48, 32'd0);
        add(2'b11, 1, 3'd2, 32'h48, 32'd3);
        add(2'b11, 1, 3'd2, 32'h4C, 32'd4);
        for (int i = 0; i < 4; i++) add((i == 0) ? 2'b10 : 2'b11, 0, 3'd2, 32'h40 + 32'(4 * i), 0);
        run_ops(0, 0);
        for (int i = 0; i < 4; i++) chk("burst_read", rd_data[4 + i], 32'(i + 1));

        // Two wait states.
        add(2'b10, 1, 3'd2, 32'h20, 32'h12345678);
        add(2'b10, 0, 3'd2, 32'h20, 32'h0);
        add(2'b10, 1, 3'd2, 32'h50, 32'h0BADF00D);
        run_ops(1, 0);
        chk("ws2_stall_wr", 32'(rd_stall[0]), 32'd2);
        chk("ws2_read", rd_data[1], 32'h12345678);

        // Reset during the second wait cycle of a write aborts it.
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = 32'h50;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        chk("wait_before_reset", 32'(hreadyout[1]), 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_hreadyout", 32'(hreadyout[1]), 32'h1);
        chk("midreset_hresp", 32'(hresp[1]), 32'h0);
        add(2'b10, 0, 3'd2, 32'h50, 32'h0);
        run_ops(1, 0);
        chk("midreset_mem_kept", rd_data[0], 32'h0BADF00D);

        // Randomised traffic with foreign-slave stalls, checked by the model.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 300; n++) begin
                r = $urandom_range(0, 9);
                a = (($urandom_range(0, 15) == 0) ? 32'h400 : 32'h0) + 32'($urandom_range(0, 127));
                if ($urandom_range(0, 7) == 0) a = 32'h3FC + 32'($urandom_range(0, 3));
                add((r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11,
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 8) / 3 + (($urandom_range(0, 15) == 0) ? 3 : 0)),
                    ($urandom_range(0, 3) == 0) ? a : (a & 32'hFFFF_FFFC), $urandom());
            end
            run_ops(d, 1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
